// File: rtl/sc_config_master.sv
// Avalon-MM master for the scan-converter config/status registers, fed by a small command FIFO.
// Optional read-until-match polling is compiled in when SC_CFG_POLL_EN is defined.
module sc_config_master #(
  parameter int FIFO_DEPTH = 4
`ifdef SC_CFG_POLL_EN
  , parameter int POLL_TIMEOUT = 4095
`endif
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic        cmd_poll_i,
  input  logic [3:0]  cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_be_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_timeout_o,
  output logic        busy_o,
  output logic [3:0]  avalon_m_address,
  output logic [31:0] avalon_m_writedata,
  output logic [3:0]  avalon_m_byteenable,
  output logic        avalon_m_write,
  output logic        avalon_m_read,
  output logic        avalon_m_chipselect,
  input  logic        avalon_m_waitrequest_n,
  input  logic [31:0] avalon_m_readdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic        write;
`ifdef SC_CFG_POLL_EN
    logic        poll;
`endif
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } cmd_t;

`ifdef SC_CFG_POLL_EN
  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_RSP, ST_POLL} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_RSP} state_t;
`endif

  state_t           state_reg;
  cmd_t             mem_reg [FIFO_DEPTH];
  cmd_t             push_cmd;
  cmd_t             head_cmd;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push;
  logic             pop;
  logic             cmd_write_reg;

  always_comb begin
    push_cmd       = '0;
    push_cmd.write = cmd_write_i;
`ifdef SC_CFG_POLL_EN
    push_cmd.poll  = cmd_poll_i;
`endif
    push_cmd.addr  = cmd_addr_i;
    push_cmd.wdata = cmd_wdata_i;
    push_cmd.be    = cmd_be_i;
  end

`ifndef SC_CFG_POLL_EN
  logic unused_poll;
  assign unused_poll = cmd_poll_i;
`endif

  // Ready comes from the registered count only, so a full FIFO never accepts even if it pops that cycle.
  assign cmd_ready_o = (count_reg != FULL_CNT);
  assign push        = cmd_valid_i && cmd_ready_o;
  assign pop         = (state_reg == ST_IDLE) && (count_reg != '0);
  assign head_cmd    = mem_reg[rd_ptr_reg];
  assign busy_o      = (state_reg != ST_IDLE) || (count_reg != '0);

  always_ff @(posedge clk_i) begin
    if (push) mem_reg[wr_ptr_reg] <= push_cmd;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

`ifdef SC_CFG_POLL_EN
  localparam int PCNT_W = $clog2(POLL_TIMEOUT + 1);
  localparam logic [PCNT_W-1:0] POLL_LAST = PCNT_W'(POLL_TIMEOUT);

  logic [31:0]       head_mask;
  logic [31:0]       poll_mask_reg;
  logic [PCNT_W-1:0] poll_cnt_reg;
  logic              cmd_poll_reg;
  logic              poll_hit;

  for (genvar gi = 0; gi < 4; gi++) begin : g_mask
    assign head_mask[gi*8 +: 8] = {8{head_cmd.be[gi]}};
  end

  // Match value stays on the write data lines during poll reads, so it doubles as the compare operand.
  assign poll_hit = ((rsp_rdata_o ^ avalon_m_writedata) & poll_mask_reg) == 32'h0;
`else
  assign rsp_timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg           <= ST_IDLE;
      cmd_write_reg       <= 1'b0;
      rsp_valid_o         <= 1'b0;
      rsp_rdata_o         <= '0;
      avalon_m_address    <= '0;
      avalon_m_writedata  <= '0;
      avalon_m_byteenable <= '0;
      avalon_m_write      <= 1'b0;
      avalon_m_read       <= 1'b0;
      avalon_m_chipselect <= 1'b0;
`ifdef SC_CFG_POLL_EN
      rsp_timeout_o       <= 1'b0;
      poll_mask_reg       <= '0;
      poll_cnt_reg        <= '0;
      cmd_poll_reg        <= 1'b0;
`endif
    end else begin
      rsp_valid_o <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (pop) begin
            cmd_write_reg       <= head_cmd.write;
            avalon_m_address    <= head_cmd.addr;
            avalon_m_writedata  <= head_cmd.wdata;
            avalon_m_byteenable <= head_cmd.write ? head_cmd.be : 4'hF;
            avalon_m_write      <= head_cmd.write;
            avalon_m_read       <= !head_cmd.write;
            avalon_m_chipselect <= 1'b1;
`ifdef SC_CFG_POLL_EN
            cmd_poll_reg        <= head_cmd.poll && !head_cmd.write;
            poll_mask_reg       <= head_mask;
            poll_cnt_reg        <= '0;
`endif
            state_reg           <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (avalon_m_waitrequest_n) begin
            avalon_m_write      <= 1'b0;
            avalon_m_read       <= 1'b0;
            avalon_m_chipselect <= 1'b0;
            if (cmd_write_reg) begin
              state_reg <= ST_IDLE;
            end else begin
              rsp_rdata_o <= avalon_m_readdata;
`ifdef SC_CFG_POLL_EN
              if (cmd_poll_reg) begin
                state_reg <= ST_POLL;
              end else begin
                rsp_valid_o   <= 1'b1;
                rsp_timeout_o <= 1'b0;
                state_reg     <= ST_RSP;
              end
`else
              rsp_valid_o <= 1'b1;
              state_reg   <= ST_RSP;
`endif
            end
          end
        end
        ST_RSP: begin
          state_reg <= ST_IDLE;
        end
`ifdef SC_CFG_POLL_EN
        ST_POLL: begin
          if (poll_hit || (poll_cnt_reg == POLL_LAST)) begin
            rsp_valid_o   <= 1'b1;
            rsp_timeout_o <= !poll_hit;
            state_reg     <= ST_RSP;
          end else begin
            poll_cnt_reg        <= poll_cnt_reg + 1'b1;
            avalon_m_read       <= 1'b1;
            avalon_m_chipselect <= 1'b1;
            state_reg           <= ST_XFER;
          end
        end
`endif
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_config_master.sv
// Scoreboard bench for sc_config_master: expected Avalon transfers and responses are queued at
// command time and retired by a negedge monitor that also plays the Avalon slave.
module tb_sc_config_master;

  typedef struct packed {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
  } txn_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_write_i = 1'b0;
  logic        cmd_poll_i = 1'b0;
  logic [3:0]  cmd_addr_i = '0;
  logic [31:0] cmd_wdata_i = '0;
  logic [3:0]  cmd_be_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_timeout_o;
  logic        busy_o;
  logic [3:0]  avalon_m_address;
  logic [31:0] avalon_m_writedata;
  logic [3:0]  avalon_m_byteenable;
  logic        avalon_m_write;
  logic        avalon_m_read;
  logic        avalon_m_chipselect;
  logic        avalon_m_waitrequest_n = 1'b0;
  logic [31:0] avalon_m_readdata;

  logic [31:0] rd_mem [16];
  txn_t        av_q[$];
  logic [32:0] rsp_q[$];

  int n_tests = 0;
  int n_fail = 0;
  int stall_cycles = 0;
  int wait_cnt = 0;
  int strobe_len = 0;
  int len_check_en = 0;
  int accepts = 0;
  int reads_seen = 0;
  int flip_after = 0;
  int flip_pending = 0;
  logic [3:0]  flip_addr = '0;
  logic [31:0] flip_val = '0;
  logic        prev_accept = 1'b0;

  always #5 clk_i = ~clk_i;

  assign avalon_m_readdata = rd_mem[avalon_m_address];

  sc_config_master #(
    .FIFO_DEPTH(4)
`ifdef SC_CFG_POLL_EN
    , .POLL_TIMEOUT(7)
`endif
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_poll_i(cmd_poll_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_be_i(cmd_be_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_timeout_o(rsp_timeout_o),
    .busy_o(busy_o),
    .avalon_m_address(avalon_m_address), .avalon_m_writedata(avalon_m_writedata),
    .avalon_m_byteenable(avalon_m_byteenable), .avalon_m_write(avalon_m_write),
    .avalon_m_read(avalon_m_read), .avalon_m_chipselect(avalon_m_chipselect),
    .avalon_m_waitrequest_n(avalon_m_waitrequest_n), .avalon_m_readdata(avalon_m_readdata)
  );

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave model and monitor: everything is sampled on the falling edge.
  always @(negedge clk_i) begin
    txn_t exp;
    if (flip_pending != 0) begin
      rd_mem[flip_addr] = flip_val;
      flip_pending = 0;
    end
    if (prev_accept) check("no_b2b_strobe", 33'(avalon_m_chipselect), 33'd0);
    prev_accept = 1'b0;
    if (avalon_m_write || avalon_m_read) begin
      check("strobe_has_cs", 33'(avalon_m_chipselect), 33'd1);
      check("rw_exclusive", 33'(avalon_m_write && avalon_m_read), 33'd0);
    end
    if (avalon_m_chipselect && !rst_i) begin
      strobe_len++;
      if (wait_cnt < stall_cycles) begin
        avalon_m_waitrequest_n = 1'b0;
        wait_cnt++;
      end else begin
        avalon_m_waitrequest_n = 1'b1;
        wait_cnt = 0;
        prev_accept = 1'b1;
        accepts++;
        if (len_check_en != 0) check("strobe_len", 33'(strobe_len), 33'(stall_cycles + 1));
        if (av_q.size() == 0) begin
          check("av_unexpected", 33'd1, 33'd0);
        end else begin
          exp = av_q.pop_front();
          $display("[TB] avalon %s addr=%0d data=%h be=%b", avalon_m_write ? "WR" : "RD",
                   avalon_m_address, avalon_m_write ? avalon_m_writedata : avalon_m_readdata,
                   avalon_m_byteenable);
          check("av_write", 33'(avalon_m_write), 33'(exp.wr));
          check("av_read", 33'(avalon_m_read), 33'(!exp.wr));
          check("av_addr", 33'(avalon_m_address), 33'(exp.addr));
          check("av_be", 33'(avalon_m_byteenable), 33'(exp.be));
          if (exp.wr) check("av_wdata", 33'(avalon_m_writedata), 33'(exp.data));
        end
        if (avalon_m_read) begin
          reads_seen++;
          if (reads_seen == flip_after) flip_pending = 1;
        end
      end
    end else begin
      avalon_m_waitrequest_n = 1'b0;
      wait_cnt = 0;
      strobe_len = 0;
    end
    if (rsp_valid_o) begin
      $display("[TB] rsp rdata=%h timeout=%b", rsp_rdata_o, rsp_timeout_o);
      if (rsp_q.size() == 0) check("rsp_unexpected", 33'd1, 33'd0);
      else check("rsp", {rsp_timeout_o, rsp_rdata_o}, rsp_q.pop_front());
    end
  end

  // Called right after a rising edge; returns right after the edge that accepted the command.
  task automatic send_cmd(input logic wr, input logic poll, input logic [3:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int n_reads);
    int guard;
    if (wr) av_q.push_back('{wr: 1'b1, addr: addr, data: wdata, be: be});
    else for (int i = 0; i < n_reads; i++) av_q.push_back('{wr: 1'b0, addr: addr, data: 32'h0, be: 4'hF});
    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_poll_i  = poll;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    cmd_be_i    = be;
    guard = 0;
    @(negedge clk_i);
    while (!cmd_ready_o && guard < 300) begin
      guard++;
      @(negedge clk_i);
    end
    if (!cmd_ready_o) check("cmd_ready_timeout", 33'd0, 33'd1);
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(posedge clk_i);
      #1;
      if (av_q.size() == 0 && rsp_q.size() == 0 && !busy_o && !rsp_valid_o) done = 1'b1;
    end
    check("drain", 33'(done), 33'd1);
  endtask

  initial begin
    logic        wr;
    logic [3:0]  addr;
    int          acc0;
    for (int i = 0; i < 16; i++) rd_mem[i] = $urandom;
    rd_mem[0] = 32'h12345678;

    // Reset values
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_cmd_ready", 33'(cmd_ready_o), 33'd1);
    check("rst_busy", 33'(busy_o), 33'd0);
    check("rst_rsp_valid", 33'(rsp_valid_o), 33'd0);
    check("rst_rsp_timeout", 33'(rsp_timeout_o), 33'd0);
    check("rst_rsp_rdata", 33'(rsp_rdata_o), 33'd0);
    check("rst_strobes", 33'({avalon_m_write, avalon_m_read, avalon_m_chipselect}), 33'd0);
    check("rst_addr_be", 33'({avalon_m_address, avalon_m_byteenable}), 33'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Single zero-wait write: one strobe cycle, no response
    len_check_en = 1;
    stall_cycles = 0;
    send_cmd(1'b1, 1'b0, 4'd2, 32'hDEADBEEF, 4'b0101, 0);
    wait_idle();

    // Read with three wait states
    stall_cycles = 3;
    rsp_q.push_back({1'b0, 32'h12345678});
    send_cmd(1'b0, 1'b0, 4'd0, 32'h0, 4'b0000, 1);
    wait_idle();

    // Mixed traffic, one wait state each, back to back
    stall_cycles = 1;
    for (int n = 0; n < 8; n++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = 4'($urandom_range(0, 15));
      if (!wr) rsp_q.push_back({1'b0, rd_mem[addr]});
      send_cmd(wr, 1'b0, addr, $urandom, 4'($urandom_range(0, 15)), 1);
    end
    wait_idle();

    // Fill the FIFO behind a stalled transfer: 1 in flight + 4 queued
    len_check_en = 0;
    stall_cycles = 1000;
    for (int n = 0; n < 5; n++) begin
      wr   = (n % 2 == 0);
      addr = 4'(n + 4);
      if (!wr) rsp_q.push_back({1'b0, rd_mem[addr]});
      send_cmd(wr, 1'b0, addr, 32'hA5A50000 + 32'(n), 4'(n + 1), 1);
    end
    @(negedge clk_i);
    check("full_cmd_ready", 33'(cmd_ready_o), 33'd0);
    check("full_busy", 33'(busy_o), 33'd1);
    stall_cycles = 0;
    @(posedge clk_i);
    #1;
    wait_idle();

`ifdef SC_CFG_POLL_EN
    // Poll matching on the third read
    len_check_en = 1;
    stall_cycles = 0;
    rd_mem[1] = 32'hABCD0000;
    reads_seen = 0;
    flip_after = 2;
    flip_addr = 4'd1;
    flip_val = 32'hABCD0001;
    rsp_q.push_back({1'b0, 32'hABCD0001});
    send_cmd(1'b0, 1'b1, 4'd1, 32'h00000001, 4'b0001, 3);
    wait_idle();

    // Poll that never matches: POLL_TIMEOUT+1 reads then a timeout response
    flip_after = 0;
    rd_mem[3] = 32'h00000055;
    rsp_q.push_back({1'b1, 32'h00000055});
    send_cmd(1'b0, 1'b1, 4'd3, 32'h000000AA, 4'b0001, 8);
    wait_idle();
`else
    // Poll flag is ignored without the poll option: a single plain read
    len_check_en = 1;
    stall_cycles = 0;
    rd_mem[5] = 32'hCAFEF00D;
    rsp_q.push_back({1'b0, 32'hCAFEF00D});
    send_cmd(1'b0, 1'b1, 4'd5, 32'h00000001, 4'b0001, 1);
    wait_idle();
`endif

    // Reset while a write is stalled and two more are queued
    len_check_en = 0;
    stall_cycles = 1000;
    send_cmd(1'b1, 1'b0, 4'd2, 32'h11111111, 4'hF, 0);
    send_cmd(1'b1, 1'b0, 4'd7, 32'h22222222, 4'hF, 0);
    send_cmd(1'b1, 1'b0, 4'd8, 32'h33333333, 4'hF, 0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("mid_rst_write", 33'(avalon_m_write), 33'd0);
    check("mid_rst_cs", 33'(avalon_m_chipselect), 33'd0);
    check("mid_rst_busy", 33'(busy_o), 33'd0);
    check("mid_rst_ready", 33'(cmd_ready_o), 33'd1);
    av_q.delete();
    acc0 = accepts;
    stall_cycles = 0;
    repeat (20) @(posedge clk_i);
    @(negedge clk_i);
    check("mid_rst_no_issue", 33'(accepts - acc0), 33'd0);
    check("mid_rst_idle", 33'(busy_o), 33'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
